apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

APB register-bank slave that sits directly downstream of `apb_master`. It consumes `pselx`/`penable`/`paddr`/`pwrite`/`pwdata` and answers with `pready`/`prdata`.

- Holds `NUM_REGS` 32-bit words. Words 0..NUM_REGS-2 are read/write; word NUM_REGS-1 is a read-only STATUS word.
- Tracks the APB phase sequence with a state machine.
- Optionally inserts a configurable number of wait states.
- Flags protocol violations through a sticky error bit and an interrupt.

## Interface
Parameters:
- `NUM_REGS`, default 16: number of 32-bit words. Must be a power of two and ≥ 2. IDX_W = $clog2(NUM_REGS).
- `WAIT_CYCLES`, default 2: wait states per access, range 0..15. Only used with `APB_SLAVE_WAIT_EN`.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pselx` in 1: slave select.
- `penable` in 1: access-phase strobe.
- `paddr` in 32: byte address.
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in 32: write data.
- `pready` out 1: transfer completes in this cycle.
- `prdata` out 32: read data, valid only while `pready` = 1 on a read.
- `irq` out 1: equals the sticky protocol-error bit.

## Operation
- Address decode:
  - idx = paddr[2 +: IDX_W]; paddr[1:0] are ignored.
  - A transfer is in range iff paddr[31:IDX_W+2] == 0.
  - Out-of-range writes are dropped; out-of-range reads return 0. Both still complete with `pready`.
- Phase FSM, states IDLE / SETUP / ACCESS, evaluated every cycle from pselx/penable:
  - pselx=0 → IDLE.
  - pselx=1, penable=0 → SETUP.
  - pselx=1, penable=1 → ACCESS.
  - ACCESS with pready=1 returns to SETUP or IDLE next cycle, according to the inputs.
- Protocol violation: pselx=1 and penable=1 in a cycle whose registered state is IDLE, meaning no preceding setup phase.
  - Sets `err` sticky at the next edge.
  - The transfer is still served normally.
  - penable=1 with pselx=0 is ignored.
- Write commit: at the edge where pselx&penable&pready&pwrite = 1, for idx < NUM_REGS-1 and in range.
- STATUS word (idx NUM_REGS-1):
  - Layout: bit0 = err; bits[15:1] = 0; bits[31:16] = xfer_cnt.
  - xfer_cnt is 16 bits and increments on every completed transfer (pready=1), reads and writes alike. It wraps 0xFFFF→0x0000.
  - A write to STATUS with pwdata[0]=1 clears err (W1C).
  - If a clear and a new violation happen in the same cycle, set wins.
  - Writes to STATUS bits[31:1] are ignored.
- `prdata` = selected word when pready & !pwrite, else 32'h0. It is combinational from the register array and status.
- Read of STATUS during its own completing cycle returns xfer_cnt before that cycle's increment.

## Timing
- Reset values:
  - pready = 0, prdata = 0, irq = 0.
  - All words = 0, err = 0, xfer_cnt = 0.
  - FSM = IDLE, wait counter = 0.
- Reset mid-transfer aborts the transfer: no write commit, no count increment. If pselx&penable are still high in the first cycle after reset, that is a violation (state IDLE).
- Wait states, with `APB_SLAVE_WAIT_EN`:
  - wait counter wcnt clears whenever not in access phase (pselx&penable = 0) and after each pready.
  - wcnt increments each access-phase cycle with pready = 0.
  - pready = pselx & penable & (wcnt == WAIT_CYCLES).
  - The first access cycle is A0, so pready rises in cycle A0+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives zero-wait behaviour.
- If pselx drops during wait states, wcnt clears, nothing commits, and err is unaffected.
- Back-to-back transfers (ACCESS→SETUP) are fully supported with no dead cycle.

## Configuration
- Macro: `APB_SLAVE_WAIT_EN`.
- Defined: wait counter and WAIT_CYCLES wait-state insertion as specified in Timing.
- Undefined: no wait counter; pready = pselx & penable, so every access completes in its first ACCESS cycle; WAIT_CYCLES is ignored.

## Test plan
- Reset then write 32'hA5A5_1234 to 0x04, followed by a read of 0x04. Required, macro on with WAIT_CYCLES=2:
  - pready rises on the 3rd access cycle.
  - prdata = 32'hA5A5_1234 during the read's pready cycle.
  - STATUS reads 32'h0002_0000.
- Read of 0x40 (out of range for NUM_REGS=16) → pready asserted, prdata = 0. Write of 32'hFFFF_FFFF to 0x40 → no word changes.
- pselx=1, penable=1 directly from IDLE → transfer completes, err=1 and irq=1 the next cycle. Write 32'h1 to STATUS (0x3C) → irq=0 after the commit edge.
- Assert rst while in a wait state of a write to 0x08 → word 2 stays 0, pready=0, xfer_cnt=0.
- Issue 65536 completed reads → xfer_cnt wraps to 0.
- Back-to-back writes with no idle cycle:
  - Macro off: pready on the first ACCESS cycle of each transfer, and both words are written.
  - Macro on with WAIT_CYCLES=0: same result.

Source files
------------

// File: rtl/apb_slave_regs.sv
// APB register-bank slave: NUM_REGS words, last word is a read-only STATUS (err, xfer_cnt).
// Optional wait-state insertion is enabled by defining APB_SLAVE_WAIT_EN.
module apb_slave_regs #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pselx,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        irq
);

    localparam int unsigned IDX_W    = $clog2(NUM_REGS);
    localparam int unsigned STAT_IDX = NUM_REGS - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_regs [NUM_REGS-1];
    logic               r_err;
    logic [15:0]        r_xfer_cnt;

    logic [IDX_W-1:0]   w_idx;
    logic               w_in_range;
    logic               w_access;
    logic               w_wait_done;
    logic               w_commit;
    logic               w_is_stat;
    logic               w_wr_reg;
    logic               w_clr_err;
    logic               w_viol;
    logic [31:0]        w_status;
    logic               w_unused;

    assign w_idx      = paddr[2 +: IDX_W];
    assign w_in_range = (paddr[31:IDX_W+2] == '0);
    assign w_access   = pselx & penable;
    assign w_is_stat  = (w_idx == IDX_W'(STAT_IDX));

    // Phase state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Phase decode follows the bus every cycle
    always_comb begin
        w_state_nxt = S_IDLE;
        if (pselx) begin
            if (penable) w_state_nxt = S_ACCESS;
            else         w_state_nxt = S_SETUP;
        end
    end

`ifdef APB_SLAVE_WAIT_EN
    logic [3:0] r_wcnt;

    // Counts stalled access cycles; restarts outside access and after completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_wcnt <= 4'd0;
        else if (!w_access || pready) r_wcnt <= 4'd0;
        else                          r_wcnt <= r_wcnt + 4'd1;
    end

    assign w_wait_done = (r_wcnt == 4'(WAIT_CYCLES));
    assign w_unused    = ^paddr[1:0];
`else
    assign w_wait_done = 1'b1;
    assign w_unused    = ^{paddr[1:0], 4'(WAIT_CYCLES)};
`endif

    assign pready    = !rst && w_access && w_wait_done;
    assign w_commit  = pready && pwrite && w_in_range;
    assign w_wr_reg  = w_commit && !w_is_stat;
    assign w_clr_err = w_commit && w_is_stat && pwdata[0];
    assign w_viol    = w_access && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS) - 1; i++) r_regs[i] <= 32'h0;
        end else if (w_wr_reg) begin
            r_regs[w_idx] <= pwdata;
        end
    end

    // Sticky error: a new violation beats a same-cycle W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_err <= 1'b0;
        else if (w_viol)    r_err <= 1'b1;
        else if (w_clr_err) r_err <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_xfer_cnt <= 16'h0;
        else if (pready) r_xfer_cnt <= r_xfer_cnt + 16'h1;
    end

    assign w_status = {r_xfer_cnt, 15'h0, r_err};
    assign irq      = r_err;

    always_comb begin
        prdata = 32'h0;
        if (pready && !pwrite && w_in_range) begin
            if (w_is_stat) prdata = w_status;
            else           prdata = r_regs[w_idx];
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs; follows APB_SLAVE_WAIT_EN as passed to the build.
module tb_apb_slave_regs;

`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic        pselx;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        irq;

    int checks;
    int errors;
    int exp_cnt;

    apb_slave_regs #(.NUM_REGS(16), .WAIT_CYCLES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .pselx   (pselx),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pready  (pready),
        .prdata  (prdata),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        pselx   = 1'b0;
        penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a posedge; returns #1 after the completing edge with the bus released
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input bit direct, output logic [31:0] rd, output int lat);
        bit done;
        pselx  = 1'b1;
        paddr  = addr;
        pwrite = wr;
        pwdata = wd;
        if (!direct) begin
            penable = 1'b0;
            @(posedge clk);
            #1;
        end
        penable = 1'b1;
        lat  = 0;
        rd   = 32'h0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (pready) begin
                rd   = prdata;
                done = 1'b1;
            end else begin
                lat++;
            end
        end
        if (!done) check("timeout", {31'h0, pready}, 32'h1);
        @(posedge clk);
        #1;
        pselx   = 1'b0;
        penable = 1'b0;
        exp_cnt++;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          lat2;
        int          n;
        int          got;

        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        rst     = 1'b1;
        pselx   = 1'b0;
        penable = 1'b0;
        paddr   = 32'h0;
        pwrite  = 1'b0;
        pwdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'h0, pready}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Basic write / read / STATUS
        xfer(32'h04, 1'b1, 32'hA5A5_1234, 1'b0, rd, lat);
        check("wr04_lat", 32'(lat), 32'(EXP_LAT));
        xfer(32'h04, 1'b0, 32'h0, 1'b0, rd, lat);
        check("rd04", rd, 32'hA5A5_1234);
        check("rd04_lat", 32'(lat), 32'(EXP_LAT));
        xfer(32'h3C, 1'b0, 32'h0, 1'b0, rd, lat);
        check("status_2", rd, 32'h0002_0000);

        // Out of range: read returns 0, write aliasing word 0 is dropped
        xfer(32'h40, 1'b0, 32'h0, 1'b0, rd, lat);
        check("rd40", rd, 32'h0);
        check("rd40_lat", 32'(lat), 32'(EXP_LAT));
        xfer(32'h40, 1'b1, 32'hFFFF_FFFF, 1'b0, rd, lat);
        xfer(32'h00, 1'b0, 32'h0, 1'b0, rd, lat);
        check("word0_untouched", rd, 32'h0);
        xfer(32'h04, 1'b0, 32'h0, 1'b0, rd, lat);
        check("word1_untouched", rd, 32'hA5A5_1234);

        // Back-to-back writes, no idle cycle between them
        xfer(32'h08, 1'b1, 32'h1111_1111, 1'b0, rd, lat);
        xfer(32'h0D, 1'b1, 32'h2222_2222, 1'b0, rd, lat2);
        check("b2b_lat0", 32'(lat), 32'(EXP_LAT));
        check("b2b_lat1", 32'(lat2), 32'(EXP_LAT));
        xfer(32'h08, 1'b0, 32'h0, 1'b0, rd, lat);
        check("b2b_word2", rd, 32'h1111_1111);
        xfer(32'h0C, 1'b0, 32'h0, 1'b0, rd, lat);
        check("b2b_word3", rd, 32'h2222_2222);
        check("irq_still_0", {31'h0, irq}, 32'h0);

        // Access without setup phase: served, and err latches
        idle(2);
        xfer(32'h04, 1'b0, 32'h0, 1'b1, rd, lat);
        check("viol_rd", rd, 32'hA5A5_1234);
        check("viol_lat", 32'(lat), 32'(EXP_LAT));
        check("viol_irq", {31'h0, irq}, 32'h1);
        xfer(32'h3C, 1'b0, 32'h0, 1'b0, rd, lat);
        check("status_err", rd, 32'h000C_0001);
        xfer(32'h3C, 1'b1, 32'h0000_0001, 1'b0, rd, lat);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        xfer(32'h3C, 1'b0, 32'h0, 1'b0, rd, lat);
        check("status_clr", rd, 32'h000E_0000);
        check("model_cnt", 32'(exp_cnt), 32'd15);

        // Reset during the first access cycle of a write to word 2
        idle(1);
        pselx   = 1'b1;
        paddr   = 32'h08;
        pwrite  = 1'b1;
        pwdata  = 32'hDEAD_BEEF;
        penable = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_pready", {31'h0, pready}, 32'h0);
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        pselx   = 1'b0;
        penable = 1'b0;
        rst     = 1'b0;
        exp_cnt = 0;
        idle(1);
        xfer(32'h3C, 1'b0, 32'h0, 1'b0, rd, lat);
        check("rst_status", rd, 32'h0);
        xfer(32'h08, 1'b0, 32'h0, 1'b0, rd, lat);
        check("rst_word2", rd, 32'h0);

`ifndef APB_SLAVE_WAIT_EN
        // Continuous access phase: one completed read per cycle until xfer_cnt wraps
        n   = 65536 - exp_cnt;
        got = 0;
        pselx   = 1'b1;
        paddr   = 32'h0;
        pwrite  = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pready) got++;
        end
        @(posedge clk);
        #1;
        pselx   = 1'b0;
        penable = 1'b0;
        check("wrap_count", 32'(got), 32'(n));
        xfer(32'h3C, 1'b0, 32'h0, 1'b0, rd, lat);
        check("wrap_status", rd, 32'h0);
        check("wrap_irq", {31'h0, irq}, 32'h0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
